// File: rtl/gpu_exec_ctrl.sv
// Execution-side GPU control: gates decoder issue from go/single-step controls, tracks
// in-flight instructions so stops land on clean boundaries, and latches host interrupts.
module gpu_exec_ctrl #(
    parameter int unsigned INFLIGHT_W = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  go_i,
    input  logic                  single_step_i,
    input  logic                  single_go_i,
    input  logic                  issue_ack_i,
    input  logic                  instr_done_i,
    input  logic                  cpu_int_i,
    input  logic                  int_ack_i,
    output logic                  run_en_o,
    output logic                  single_stop_o,
    output logic                  halted_o,
    output logic [INFLIGHT_W-1:0] inflight_o,
    output logic                  cpu_irq_o,
    output logic                  err_o
);

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StDrain,
        StStepHalt,
        StStepIssue,
        StStepDrain
    } state_e;

    localparam logic [INFLIGHT_W-1:0] InflightMax = {INFLIGHT_W{1'b1}};

    state_e                state_q, state_d;
    logic [INFLIGHT_W-1:0] inflight_q, inflight_d;
    logic                  err_q, err_d;
    logic                  cpu_irq_q, cpu_irq_d;
    logic                  inflight_zero;

    assign inflight_zero = (inflight_q == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            inflight_q <= '0;
            err_q      <= 1'b0;
            cpu_irq_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            cpu_irq_q  <= cpu_irq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (go_i && !single_step_i) begin
                    state_d = StRun;
                end else if (go_i && single_step_i) begin
                    state_d = StStepDrain;
                end
            end
            StRun: begin
                if (!go_i) begin
                    state_d = StDrain;
                end else if (single_step_i) begin
                    state_d = StStepDrain;
                end
            end
            // A mid-drain go only takes effect once the pipeline is empty.
            StDrain: begin
                if (inflight_zero) begin
                    if (go_i && !single_step_i) begin
                        state_d = StRun;
                    end else if (go_i && single_step_i) begin
                        state_d = StStepDrain;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StStepDrain: begin
                if (inflight_zero) begin
                    state_d = go_i ? StStepHalt : StIdle;
                end
            end
            StStepHalt: begin
                if (!go_i) begin
                    state_d = StIdle;
                end else if (!single_step_i) begin
                    state_d = StRun;
                end else if (single_go_i) begin
                    state_d = StStepIssue;
                end
            end
            StStepIssue: begin
                if (!go_i) begin
                    state_d = StDrain;
                end else if (issue_ack_i) begin
                    state_d = StStepDrain;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        err_d      = err_q;
        if (issue_ack_i && !instr_done_i) begin
            if (inflight_q == InflightMax) begin
                err_d = 1'b1;
            end else begin
                inflight_d = inflight_q + 1'b1;
            end
        end else if (!issue_ack_i && instr_done_i) begin
            if (inflight_zero) begin
                err_d = 1'b1;
            end else begin
                inflight_d = inflight_q - 1'b1;
            end
        end
    end

    // Set beats clear when a new interrupt coincides with the host acknowledge.
    assign cpu_irq_d = cpu_int_i | (cpu_irq_q & ~int_ack_i);

    always_comb begin
        run_en_o      = 1'b0;
        single_stop_o = 1'b0;
        halted_o      = 1'b0;
        unique case (state_q)
            StIdle:      halted_o      = 1'b1;
            StRun:       run_en_o      = 1'b1;
            StStepHalt:  single_stop_o = 1'b1;
            StStepIssue: run_en_o      = 1'b1;
            default:     ;
        endcase
    end

    assign inflight_o = inflight_q;
    assign cpu_irq_o  = cpu_irq_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_gpu_exec_ctrl.sv
// Directed bench for gpu_exec_ctrl: run/drain, single stepping, counter limits,
// interrupt latch and asynchronous reset.
module tb_gpu_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       go, ss, sgo, ack, done, cint, iack;
    logic       run_en, single_stop, halted, cpu_irq, err;
    logic [2:0] inflight;

    int n_tests = 0;
    int n_fail  = 0;
    int runcnt;

    gpu_exec_ctrl #(.INFLIGHT_W(3)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .go_i          (go),
        .single_step_i (ss),
        .single_go_i   (sgo),
        .issue_ack_i   (ack),
        .instr_done_i  (done),
        .cpu_int_i     (cint),
        .int_ack_i     (iack),
        .run_en_o      (run_en),
        .single_stop_o (single_stop),
        .halted_o      (halted),
        .inflight_o    (inflight),
        .cpu_irq_o     (cpu_irq),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        {go, ss, sgo, ack, done, cint, iack} = '0;
        #2;
        check("rst_run_en", 32'(run_en), 0);
        check("rst_single_stop", 32'(single_stop), 0);
        check("rst_halted", 32'(halted), 1);
        check("rst_inflight", 32'(inflight), 0);
        check("rst_irq", 32'(cpu_irq), 0);
        check("rst_err", 32'(err), 0);
        rst = 1'b0;

        // 1: run, issue three, drop go, drain
        go = 1'b1;
        tick();
        check("t1_run_en", 32'(run_en), 1);
        check("t1_not_halted", 32'(halted), 0);
        ack = 1'b1;
        repeat (3) tick();
        ack = 1'b0;
        check("t1_inflight3", 32'(inflight), 3);
        go = 1'b0;
        tick();
        check("t1_drain_run_en", 32'(run_en), 0);
        check("t1_drain_halted", 32'(halted), 0);
        done = 1'b1;
        tick();
        tick();
        check("t1_inflight1", 32'(inflight), 1);
        tick();
        done = 1'b0;
        check("t1_inflight0", 32'(inflight), 0);
        check("t1_halted_late", 32'(halted), 0);
        tick();
        check("t1_halted", 32'(halted), 1);

        // 2: single step from idle
        go = 1'b1;
        ss = 1'b1;
        tick();
        check("t2_stepdrain_run_en", 32'(run_en), 0);
        check("t2_stepdrain_stop", 32'(single_stop), 0);
        tick();
        check("t2_stephalt_stop", 32'(single_stop), 1);
        sgo = 1'b1;
        tick();
        sgo = 1'b0;
        runcnt = 0;
        if (run_en) runcnt++;
        tick();
        if (run_en) runcnt++;
        tick();
        if (run_en) runcnt++;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        if (run_en) runcnt++;
        check("t2_run_cycles", 32'(runcnt), 3);
        check("t2_inflight1", 32'(inflight), 1);
        check("t2_stepdrain_stop2", 32'(single_stop), 0);
        sgo = 1'b1;
        tick();
        sgo = 1'b0;
        check("t2_sgo_ignored", 32'(run_en), 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("t2_inflight0", 32'(inflight), 0);
        check("t2_stop_late", 32'(single_stop), 0);
        tick();
        check("t2_stop", 32'(single_stop), 1);

        // 6a: leave stepping straight to run
        ss = 1'b0;
        tick();
        check("t6_run_en", 32'(run_en), 1);
        check("t6_stop_clear", 32'(single_stop), 0);

        // 3: simultaneous ack/done, saturation
        ack = 1'b1;
        repeat (2) tick();
        done = 1'b1;
        repeat (5) tick();
        {ack, done} = '0;
        check("t3_both_const", 32'(inflight), 2);
        check("t3_no_err", 32'(err), 0);
        go = 1'b0;
        done = 1'b1;
        repeat (2) tick();
        done = 1'b0;
        check("t3_zero", 32'(inflight), 0);
        ack = 1'b1;
        repeat (7) tick();
        check("t3_seven", 32'(inflight), 7);
        check("t3_err_pre", 32'(err), 0);
        tick();
        ack = 1'b0;
        check("t3_sat", 32'(inflight), 7);
        check("t3_err_set", 32'(err), 1);
        done = 1'b1;
        repeat (7) tick();
        done = 1'b0;
        check("t3_drained", 32'(inflight), 0);
        check("t3_err_sticky", 32'(err), 1);
        tick();
        check("t3_halted", 32'(halted), 1);

        // 4: interrupt latch, underflow
        rst = 1'b1;
        #1;
        check("t4_err_rst", 32'(err), 0);
        rst = 1'b0;
        cint = 1'b1;
        iack = 1'b1;
        tick();
        cint = 1'b0;
        check("t4_set_wins", 32'(cpu_irq), 1);
        tick();
        iack = 1'b0;
        check("t4_irq_clr", 32'(cpu_irq), 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("t4_under_err", 32'(err), 1);
        check("t4_under_cnt", 32'(inflight), 0);

        // 5: asynchronous reset mid-run
        rst = 1'b1;
        #1;
        rst = 1'b0;
        go = 1'b1;
        tick();
        ack = 1'b1;
        cint = 1'b1;
        tick();
        cint = 1'b0;
        tick();
        ack = 1'b0;
        check("t5_inflight2", 32'(inflight), 2);
        check("t5_irq", 32'(cpu_irq), 1);
        go = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_run_en", 32'(run_en), 0);
        check("t5_rst_halted", 32'(halted), 1);
        check("t5_rst_inflight", 32'(inflight), 0);
        check("t5_rst_irq", 32'(cpu_irq), 0);
        rst = 1'b0;
        repeat (2) tick();
        check("t5_stay_idle", 32'(halted), 1);
        go = 1'b1;
        tick();
        check("t5_go_run", 32'(run_en), 1);

        // 6b: drop go while a step is issuing
        ss = 1'b1;
        repeat (2) tick();
        check("t6_stephalt", 32'(single_stop), 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("t6_halt_hold", 32'(single_stop), 1);
        sgo = 1'b1;
        tick();
        sgo = 1'b0;
        check("t6_issue", 32'(run_en), 1);
        go = 1'b0;
        tick();
        check("t6_drain_run_en", 32'(run_en), 0);
        check("t6_drain_halted", 32'(halted), 0);
        tick();
        check("t6_drain_wait", 32'(halted), 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("t6_inflight0", 32'(inflight), 0);
        tick();
        check("t6_idle", 32'(halted), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
